// File: rtl/dsm_mod2.sv
// Second-order 1-bit delta-sigma modulator (CIFB, two saturating integrators).
// Adds overload detection with timed integrator recovery and an idle toggle pattern.
module dsm_mod2 #(
  parameter int IN_W        = 16,
  parameter int ACC_W       = 20,
  parameter int OVF_LIMIT   = 16,
  parameter int RECOVER_CYC = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic signed [IN_W-1:0] x_in,
  output logic                   dout,
  output logic                   overload,
  output logic [7:0]             ovf_cnt,
  output logic                   running
);

  localparam int SUM_W = ACC_W + 2;
  localparam int SAT_W = $clog2(OVF_LIMIT + 1);
  localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FB_POS  =
    {{(SUM_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FB_NEG  =
    {{(SUM_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic                     dout_q, dout_d;
  logic                     overload_q, overload_d;
  logic [7:0]               ovf_cnt_q, ovf_cnt_d;
  logic                     running_q, running_d;
  logic [SAT_W-1:0]         sat_cnt_q, sat_cnt_d;
  logic [REC_W-1:0]         rec_cnt_q, rec_cnt_d;

  logic signed [SUM_W-1:0]  fb, x_ext, i1_ext, i2_ext, sum1, sum2;
  logic signed [ACC_W-1:0]  i1_sat, i2_sat;
  logic                     clamp1, clamp2, clamped;

  // Integrator datapath: sums carry two guard bits so the clamp never sees a wrap.
  always_comb begin
    x_ext  = {{(SUM_W-IN_W){x_in[IN_W-1]}}, x_in};
    i1_ext = {{2{i1_q[ACC_W-1]}}, i1_q};
    i2_ext = {{2{i2_q[ACC_W-1]}}, i2_q};
    fb     = dout_q ? FB_POS : FB_NEG;
    sum1   = i1_ext + x_ext - fb;
    sum2   = i2_ext + i1_ext - fb;

    clamp1 = 1'b1;
    if (sum1 > ACC_MAX)      i1_sat = ACC_MAX[ACC_W-1:0];
    else if (sum1 < ACC_MIN) i1_sat = ACC_MIN[ACC_W-1:0];
    else begin
      i1_sat = sum1[ACC_W-1:0];
      clamp1 = 1'b0;
    end

    clamp2 = 1'b1;
    if (sum2 > ACC_MAX)      i2_sat = ACC_MAX[ACC_W-1:0];
    else if (sum2 < ACC_MIN) i2_sat = ACC_MIN[ACC_W-1:0];
    else begin
      i2_sat = sum2[ACC_W-1:0];
      clamp2 = 1'b0;
    end

    clamped = clamp1 | clamp2;
  end

  // Outside steady RUN the integrators are parked at zero and dout toggles.
  always_comb begin
    state_d    = state_q;
    i1_d       = '0;
    i2_d       = '0;
    dout_d     = ~dout_q;
    overload_d = 1'b0;
    ovf_cnt_d  = ovf_cnt_q;
    sat_cnt_d  = '0;
    rec_cnt_d  = '0;

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (clamped && (sat_cnt_q == SAT_W'(OVF_LIMIT - 1))) begin
            state_d    = RECOVER;
            overload_d = 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
          end else begin
            i1_d      = i1_sat;
            i2_d      = i2_sat;
            dout_d    = ~i2_sat[ACC_W-1];
            sat_cnt_d = clamped ? (sat_cnt_q + 1'b1) : '0;
          end
        end
        RECOVER: begin
          if (rec_cnt_q == REC_W'(RECOVER_CYC - 1)) state_d = RUN;
          else rec_cnt_d = rec_cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      i1_q       <= '0;
      i2_q       <= '0;
      dout_q     <= 1'b0;
      overload_q <= 1'b0;
      ovf_cnt_q  <= '0;
      running_q  <= 1'b0;
      sat_cnt_q  <= '0;
      rec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      dout_q     <= dout_d;
      overload_q <= overload_d;
      ovf_cnt_q  <= ovf_cnt_d;
      running_q  <= running_d;
      sat_cnt_q  <= sat_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end

  assign dout     = dout_q;
  assign overload = overload_q;
  assign ovf_cnt  = ovf_cnt_q;
  assign running  = running_q;

endmodule

// File: tb/tb_dsm_mod2.sv
// Directed bench for dsm_mod2: reset, idle pattern, ones density, overload/recovery
// and overload-counter saturation, all sampled on the falling clock edge.
module tb_dsm_mod2;

  logic               clock;
  logic               reset;
  logic               en;
  logic signed [15:0] x_in;
  logic               dout;
  logic               overload;
  logic [7:0]         ovf_cnt;
  logic               running;

  int n_checks = 0;
  int n_fail   = 0;

  dsm_mod2 dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .x_in     (x_in),
    .dout     (dout),
    .overload (overload),
    .ovf_cnt  (ovf_cnt),
    .running  (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("chk  %s got=%0d exp=%0d ok", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Count ones over n samples, noting any overload pulse seen meanwhile.
  task automatic count_ones(input int n, output int ones, output int ovl);
    ones = 0;
    ovl  = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      ones += int'(dout);
      ovl  += int'(overload);
    end
  endtask

  // Wait for the next overload pulse; found=0 if the budget expires.
  task automatic wait_overload(input int budget, output int found);
    found = 0;
    for (int k = 0; k < budget && found == 0; k++) begin
      tick();
      if (overload) found = 1;
    end
  endtask

  initial begin
    int       ones, ovl, found, toggles, run_hi, ovl_hi, pulses, wide, cnt_bad;
    logic [7:0] pat;
    logic     prev;

    reset = 1'b0;
    en    = 1'b0;
    x_in  = '0;
    repeat (3) tick();
    check("rst_dout", int'(dout), 0);
    check("rst_overload", int'(overload), 0);
    check("rst_ovf_cnt", int'(ovf_cnt), 0);
    check("rst_running", int'(running), 0);

    // First cycles from reset with x=0: dout follows 1,0,0,1 repeating.
    en    = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      pat[7-k] = dout;
      if (k == 0) check("release_running", int'(running), 1);
    end
    check("zero_start_pattern", int'(pat), int'(8'b1001_1001));

    repeat (32) tick();
    count_ones(2048, ones, ovl);
    $display("info x=0 ones=%0d of 2048", ones);
    check("zero_density_window", int'(ones >= 1020 && ones <= 1028), 1);
    check("zero_no_overload", ovl, 0);

    x_in = 16'sd16384;
    repeat (32) tick();
    count_ones(4096, ones, ovl);
    $display("info x=+16384 ones=%0d of 4096", ones);
    check("half_pos_density_window", int'(ones >= 3031 && ones <= 3113), 1);

    x_in = -16'sd16384;
    repeat (32) tick();
    count_ones(4096, ones, ovl);
    $display("info x=-16384 ones=%0d of 4096", ones);
    check("half_neg_density_window", int'(ones >= 983 && ones <= 1065), 1);

    en = 1'b0;
    tick();
    check("idle_running", int'(running), 0);
    prev = dout;
    toggles = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (dout != prev) toggles++;
      prev = dout;
    end
    check("idle_toggles", toggles, 8);

    // Full-scale input: one overload pulse, 64 cycles of RECOVER, then RUN.
    en   = 1'b1;
    x_in = 16'sd32767;
    wait_overload(4096, found);
    check("ovl1_seen", found, 1);
    check("ovl1_running_low", int'(running), 0);
    check("ovl1_ovf_cnt", int'(ovf_cnt), 1);
    prev = dout;
    toggles = 0;
    run_hi  = 0;
    ovl_hi  = 0;
    for (int k = 1; k < 64; k++) begin
      tick();
      if (dout != prev) toggles++;
      prev = dout;
      run_hi += int'(running);
      ovl_hi += int'(overload);
    end
    check("recover_dout_toggles", toggles, 63);
    check("recover_running_low", run_hi, 0);
    check("overload_one_cycle", ovl_hi, 0);
    tick();
    check("recover_exit_running", int'(running), 1);

    // Drop en in RECOVER: IDLE at once, count retained, clean restart.
    wait_overload(4096, found);
    check("ovl2_seen", found, 1);
    repeat (5) tick();
    en = 1'b0;
    tick();
    check("drop_running", int'(running), 0);
    repeat (3) tick();
    check("drop_ovf_kept", int'(ovf_cnt), 2);
    x_in = '0;
    en   = 1'b1;
    tick();
    check("restart_running", int'(running), 1);
    check("restart_i1_zero", int'(dut.i1_q == '0), 1);
    check("restart_i2_zero", int'(dut.i2_q == '0), 1);

    // Asynchronous reset mid-RUN, between clock edges.
    x_in = 16'sd12000;
    repeat (20) tick();
    #2 reset = 1'b0;
    #1;
    check("async_dout", int'(dout), 0);
    check("async_ovf_cnt", int'(ovf_cnt), 0);
    check("async_running", int'(running), 0);
    check("async_i2_zero", int'(dut.i2_q == '0), 1);
    tick();
    reset = 1'b1;
    tick();
    check("async_release_running", int'(running), 1);

    // 300 overload events: counter tracks min(n,255), pulses stay single-cycle.
    x_in    = 16'sd32767;
    pulses  = 0;
    wide    = 0;
    cnt_bad = 0;
    prev    = 1'b0;
    for (int k = 0; k < 60000 && pulses < 300; k++) begin
      tick();
      if (overload) begin
        if (prev) wide++;
        else begin
          pulses++;
          if (int'(ovf_cnt) != ((pulses > 255) ? 255 : pulses)) cnt_bad++;
        end
      end
      prev = overload;
    end
    check("sat_pulses", pulses, 300);
    check("sat_wide_pulses", wide, 0);
    check("sat_cnt_track", cnt_bad, 0);
    check("sat_ovf_final", int'(ovf_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsm_mod2.md
Name: dsm_mod2

Overview:
- Second-order, 1-bit delta-sigma modulator core (CIFB, two saturating integrators).
- Consumes the 8x-interpolated sample stream from the interpolator, `T_BITS` wide, sampled every clock.
- Produces the 1-bit pulse-density output that drives the pad/DAC filter.
- Includes overload detection with automatic integrator recovery, plus an idle mode.

Parameters:
- IN_W, 16, width of signed input sample; equals `T_BITS.
- ACC_W, 20, width of each signed integrator; must be ≥ IN_W+2.
- OVF_LIMIT, 16, consecutive clamped cycles that declare overload.
- RECOVER_CYC, 64, cycles spent in RECOVER before resuming.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  modulator enable; low forces IDLE.
- x_in  in  IN_W  signed interpolated sample.
- dout  out  1  registered pulse-density bitstream.
- overload  out  1  one-cycle pulse on entry to RECOVER.
- ovf_cnt  out  8  sticky saturating count of overload events.
- running  out  1  high while state = RUN.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, i1=i2=0, dout=0, overload=0, ovf_cnt=0, running=0, sat_cnt=0, rec_cnt=0. Takes effect immediately, including mid-operation.
- States: IDLE, RUN, RECOVER. `en` low in any state → IDLE on the next edge; en low has priority over all other transitions.
- IDLE:
  - i1, i2 held at 0.
  - dout toggles every clock (0,1,0,1…) to give a mid-scale idle pattern.
  - en high → RUN.
- RUN, per clock:
  - fb = dout ? +2^(IN_W-1) : −2^(IN_W-1), sign-extended to ACC_W.
  - x = x_in sign-extended to ACC_W.
  - i1_next = sat(i1 + x − fb).
  - i2_next = sat(i2 + i1 − fb), using the OLD i1.
  - dout_next = ~i2_next[ACC_W-1], i.e. 1 when i2_next ≥ 0.
  - Sums are computed in ACC_W+2 bits. sat() clamps to [−2^(ACC_W-1), 2^(ACC_W-1)−1].
  - A cycle is "clamped" if either sum was clamped.
- Latency: an x_in change first affects i1 at edge+1, i2 at edge+2, dout at edge+2.
- Overload detection:
  - sat_cnt increments on each clamped RUN cycle and clears on any unclamped cycle or on leaving RUN.
  - A clamped cycle with sat_cnt = OVF_LIMIT−1 makes that edge enter RECOVER.
  - On that entry: overload=1 for exactly one cycle; ovf_cnt increments, saturating at 255.
- RECOVER:
  - i1 = i2 = 0; dout toggles as in IDLE.
  - rec_cnt counts 0..RECOVER_CYC−1; at the terminal count → RUN.
  - ovf_cnt is never cleared except by reset.
- running = (state == RUN), registered with the state.
- Boundaries:
  - x_in = most-negative value (−32768 at defaults) is legal; it drives the stable-input limit.
  - Once clamped, an integrator stays at its rail until a sum brings it back in range. No wrap-around ever occurs.

Test Plan:
- Reset low mid-RUN with en=1, x_in=12000 → all outputs 0 and state IDLE immediately, with no clock edge; on release with en=1, RUN on the next edge and running=1.
- en=1, x_in=0, 2048 cycles after 32 settle cycles → count of dout ones = 1024±4; overload never asserted; i1/i2 never reach a rail.
- en=1, x_in=+16384 (half scale), 4096 cycles → ones density 0.75±0.01; x_in=−16384 → 0.25±0.01.
- en=1, x_in=+32767 held 4096 cycles → overload pulses exactly one cycle; ovf_cnt ≥ 1; state RECOVER for 64 cycles with dout alternating, then RUN.
- Overload with en dropped during RECOVER → IDLE on the next edge; ovf_cnt retained; en back high → RUN with integrators starting at 0.
- Force 300 overload events (x_in=+32767, repeated recovery) → ovf_cnt stops at 255; overload still pulses once per event.
